sll_32_sequential: RTL

//   Multi-cycle 32-bit logical left shifter (RV32 SLL/SLLI semantics): s = a << b[4:0], zero fill.
//   It is the left-direction counterpart to the structural arithmetic right shifter.
//   It performs one log-shifter stage per clock (16, 8, 4, 2, 1) under a start/busy/done handshake.
//   It sits beside the ALU as a sequential shift unit for the datapath controller.

---
 rtl/shift_pkg.sv | 14 +
 rtl/sll_stage_mux.sv | 30 +++
 rtl/sll_32_sequential.sv | 115 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential logical-left shifter.
// Imported by the stage mux and by the top-level FSM.
package shift_pkg;

    localparam int SHIFT_STAGES = 5;
    localparam int STAGE_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_t;

endpackage : shift_pkg

// File: rtl/sll_stage_mux.sv
// One stage of the logarithmic left shifter: shift by 16/8/4/2/1 for sel 0..4.
// It is purely combinational; zeros enter from bit 0.
module sll_stage_mux
    import shift_pkg::*;
(
    output logic [31:0]        y,
    input  logic [31:0]        x,
    input  logic               en,
    input  logic [STAGE_W-1:0] sel
);

    logic [31:0] shifted;

    // Select the candidate row for this stage. Out-of-range sel passes x through.
    always_comb begin
        case (sel)
            3'd0:    shifted = {x[15:0], 16'b0};
            3'd1:    shifted = {x[23:0],  8'b0};
            3'd2:    shifted = {x[27:0],  4'b0};
            3'd3:    shifted = {x[29:0],  2'b0};
            3'd4:    shifted = {x[30:0],  1'b0};
            default: shifted = x;
        endcase
    end

    for (genvar i = 0; i < 32; i++) begin : g_bit_mux
        assign y[i] = en ? shifted[i] : x[i];
    end

endmodule : sll_stage_mux

// File: rtl/sll_32_sequential.sv
// Multi-cycle 32-bit logical left shifter: s = a << b[4:0], one log-shifter stage per clock.
// Uses a start/busy/done handshake with a fixed latency of five shift cycles.
module sll_32_sequential
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = SHIFT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    shift_state_t        state_q, state_d;
    logic [WIDTH-1:0]    acc_q,   acc_d;
    logic [4:0]          amt_q,   amt_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [WIDTH-1:0]    s_q,     s_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    logic [4:0]          stage_bit;
    logic                stage_en;
    logic [WIDTH-1:0]    stage_y;

    // Stage k consumes amount bit 4-k, so the large shift goes first.
    assign stage_bit = 5'b10000 >> stage_q;
    assign stage_en  = |(amt_q & stage_bit);

    sll_stage_mux u_stage_mux (
        .y   (stage_y),
        .x   (acc_q),
        .en  (stage_en),
        .sel (stage_q)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        stage_d = stage_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = a;
                    amt_d   = b;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = stage_y;
                stage_d = stage_q + 3'd1;
                if (stage_q == STAGE_W'(STAGES - 1)) begin
                    s_d     = stage_y;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A start in the done cycle is accepted directly (back-to-back).
                if (start) begin
                    acc_d   = a;
                    amt_d   = b;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            stage_q <= stage_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;

endmodule : sll_32_sequential
